// File: rtl/lane_seg_div_pkg.sv
// Shared width defaults and controller state encoding for the lane segment divider.
package lane_seg_div_pkg;

  localparam int DIVIDEND_W_DEF = 28;
  localparam int DIVISOR_W_DEF  = 14;
  localparam int QUOT_W_DEF     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/lane_seg_div_sat.sv
// Applies signs to the unsigned quotient/remainder magnitudes and saturates the quotient.
module lane_seg_div_sat
  import lane_seg_div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF,
  parameter int QUOT_W     = QUOT_W_DEF
) (
  input  logic [DIVIDEND_W-1:0]       q_mag,
  input  logic [DIVISOR_W-1:0]        r_mag,
  input  logic                        quot_neg,
  input  logic                        rem_neg,
  input  logic                        div_zero,
  output logic signed [QUOT_W-1:0]    quot,
  output logic signed [DIVISOR_W-1:0] rem,
  output logic                        ovf
);

  localparam logic [DIVIDEND_W-1:0] POS_LIM = DIVIDEND_W'((64'd1 << (QUOT_W - 1)) - 64'd1);
  localparam logic [DIVIDEND_W-1:0] NEG_LIM = DIVIDEND_W'(64'd1 << (QUOT_W - 1));
  localparam logic signed [QUOT_W-1:0] Q_MAX = {1'b0, {(QUOT_W - 1){1'b1}}};
  localparam logic signed [QUOT_W-1:0] Q_MIN = {1'b1, {(QUOT_W - 1){1'b0}}};

  always_comb begin
    quot = '0;
    rem  = '0;
    ovf  = 1'b0;
    if (div_zero) begin
      // Divide-by-zero saturates toward the dividend's sign; rem_neg carries that sign.
      quot = rem_neg ? Q_MIN : Q_MAX;
      ovf  = 1'b1;
    end else begin
      rem = rem_neg ? DIVISOR_W'(-r_mag) : r_mag;
      if (quot_neg) begin
        if (q_mag > NEG_LIM) begin
          quot = Q_MIN;
          ovf  = 1'b1;
        end else begin
          quot = QUOT_W'(-q_mag);
        end
      end else begin
        if (q_mag > POS_LIM) begin
          quot = Q_MAX;
          ovf  = 1'b1;
        end else begin
          quot = QUOT_W'(q_mag);
        end
      end
    end
  end

endmodule

// File: rtl/lane_seg_top_sdiv_28s_14s_16_seq.sv
// Sequential signed restoring divider: one quotient bit per cycle, then a sign/saturation cycle.
module lane_seg_top_sdiv_28s_14s_16_seq
  import lane_seg_div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF,
  parameter int QUOT_W     = QUOT_W_DEF
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIVIDEND_W-1:0] din0,
  input  logic signed [DIVISOR_W-1:0]  din1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [QUOT_W-1:0]     quot,
  output logic signed [DIVISOR_W-1:0]  rem,
  output logic                         ovf,
  output logic                         dbz
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W);

  div_state_t state, state_nxt;

  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] q_reg;
  logic [DIVIDEND_W-1:0] a_abs;
  logic [DIVISOR_W-1:0]  r_reg;
  logic [DIVISOR_W-1:0]  b_mag;
  logic [DIVISOR_W-1:0]  b_abs;
  logic                  a_neg;
  logic                  b_neg;
  logic [DIVISOR_W:0]    trial;
  logic [DIVISOR_W:0]    b_ext;
  logic                  step_ge;
  logic                  accept;
  logic                  finish;

  logic signed [QUOT_W-1:0]    sat_quot;
  logic signed [DIVISOR_W-1:0] sat_rem;
  logic                        sat_ovf;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = CALC;
      CALC:    if (finish)    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && ap_rst_n;
    out_valid = (state == DONE);
  end

  always_comb begin
    accept  = in_valid && in_ready;
    finish  = (state == CALC) && (cnt == LAST_CNT);
    a_abs   = din0[DIVIDEND_W-1] ? DIVIDEND_W'(-din0) : DIVIDEND_W'(din0);
    b_abs   = din1[DIVISOR_W-1]  ? DIVISOR_W'(-din1)  : DIVISOR_W'(din1);
    trial   = {r_reg, q_reg[DIVIDEND_W-1]};
    b_ext   = {1'b0, b_mag};
    step_ge = (trial >= b_ext);
  end

  // Partial remainder stays below the divisor magnitude, so it fits DIVISOR_W bits after each step.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt   <= '0;
      q_reg <= '0;
      r_reg <= '0;
      b_mag <= '0;
      a_neg <= 1'b0;
      b_neg <= 1'b0;
      quot  <= '0;
      rem   <= '0;
      ovf   <= 1'b0;
      dbz   <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      q_reg <= a_abs;
      r_reg <= '0;
      b_mag <= b_abs;
      a_neg <= din0[DIVIDEND_W-1];
      b_neg <= din1[DIVISOR_W-1];
    end else if (finish) begin
      quot <= sat_quot;
      rem  <= sat_rem;
      ovf  <= sat_ovf;
      dbz  <= (b_mag == '0);
    end else if (state == CALC) begin
      r_reg <= DIVISOR_W'(step_ge ? (trial - b_ext) : trial);
      q_reg <= {q_reg[DIVIDEND_W-2:0], step_ge};
      cnt   <= cnt + CNT_W'(1);
    end
  end

  lane_seg_div_sat #(
    .DIVIDEND_W (DIVIDEND_W),
    .DIVISOR_W  (DIVISOR_W),
    .QUOT_W     (QUOT_W)
  ) u_sat (
    .q_mag    (q_reg),
    .r_mag    (r_reg),
    .quot_neg (a_neg ^ b_neg),
    .rem_neg  (a_neg),
    .div_zero (b_mag == '0),
    .quot     (sat_quot),
    .rem      (sat_rem),
    .ovf      (sat_ovf)
  );

endmodule
